// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that packs four consecutive good bytes into a
// 32-bit little-endian word and offers it on a single-entry valid/ready buffer.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   rxd    in   asynchronous serial input, idles high
//   rdata  out  assembled word, stable while valid
//   valid  out  rdata holds an unconsumed word
//   ready  in   consumer accepts the word (transfer on valid && ready)
//   ferr   out  one-cycle pulse: stop bit sampled low
//   ovr    out  one-cycle pulse: completed word dropped, buffer full
module uart_rx_word #(
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        ready,
  output logic        ferr,
  output logic        ovr
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLK_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [23:0]     lanes_q, lanes_d;  // byte lanes 0..2; lane 3 comes straight from shift_q
  logic            armed_q, armed_d;  // line seen high since the last framing error
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            cnt_zero;
  logic            word_done;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    lanes_d    = lanes_q;
    armed_d    = armed_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    word_done  = 1'b0;

    case (state_q)
      StIdle: begin
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end
      StStart: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rxs_q) begin
          state_d = StIdle;  // start bit did not hold to mid-bit: glitch
        end else begin
          state_d   = StData;
          cnt_d     = CntFull;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d[bit_idx_q] = rxs_q;
          cnt_d              = CntFull;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
          if (rxs_q) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    lanes_d[7:0]   = shift_q;
              2'd1:    lanes_d[15:8]  = shift_q;
              2'd2:    lanes_d[23:16] = shift_q;
              default: word_done      = 1'b1;
            endcase
          end else begin
            // Drop the byte, restart word alignment, and wait for the line to
            // return high so a held-low line cannot retrigger a start.
            ferr_d     = 1'b1;
            byte_cnt_d = 2'd0;
            armed_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      // A consumer taking the old word this cycle frees the slot for the new one.
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        rdata_d = {shift_q, lanes_q};
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 8'd0;
      lanes_q    <= 24'd0;
      armed_q    <= 1'b1;
      rdata_q    <= 32'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      lanes_q    <= lanes_d;
      armed_q    <= armed_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: table-driven word vectors, hand-written sequences for
// overflow, glitch, mid-frame reset and same-cycle consume/complete, then random
// frames checked against a byte-queue reference model.
module tb_uart_rx_word;

  localparam int unsigned Cpb = 16;
  // Edges from the first posedge after a start bit begins to the edge that
  // loads a completed word: 2 sync + 1 detect + half bit + 9 bits.
  localparam int unsigned DoneEdge = 3 + Cpb / 2 + 9 * Cpb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] rdata;
  logic        valid, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx_word #(.CLK_PER_BIT(Cpb)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rdata (rdata),
    .valid (valid),
    .ready (ready),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt = 0;
  logic [31:0] got_q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata = '0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endfunction

  // Monitor: count pulses, log transfers, and hold-check a stalled word.
  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
    if (prev_hold) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_rdata", rdata, prev_rdata);
    end
    if (valid === 1'b1 && ready && !rst) got_q.push_back(rdata);
    prev_hold  = (valid === 1'b1) && !ready && !rst;
    prev_rdata = rdata;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);  // return line high after a broken stop
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
    @(negedge clk);
  endtask

  function automatic logic [31:0] first_word();
    return (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
  endfunction

  typedef struct {
    int unsigned n_pre;     // good 0x99 bytes before the broken frame
    logic        bad;       // send a frame with a low stop bit
    logic [7:0]  bad_byte;
    logic [7:0]  tx [4];    // transmission order
    logic [31:0] exp_word;
    int unsigned exp_ferr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int unsigned f0, o0, exp_ferr;
    logic [7:0]  pend[$];
    logic [31:0] exp_q[$];

    vecs[0] = '{n_pre: 0, bad: 1'b0, bad_byte: 8'h00, tx: '{8'h78, 8'h56, 8'h34, 8'h12},
                exp_word: 32'h1234_5678, exp_ferr: 0};
    vecs[1] = '{n_pre: 0, bad: 1'b1, bad_byte: 8'hAA, tx: '{8'h11, 8'h22, 8'h33, 8'h44},
                exp_word: 32'h4433_2211, exp_ferr: 1};
    vecs[2] = '{n_pre: 0, bad: 1'b0, bad_byte: 8'h00, tx: '{8'h0D, 8'hF0, 8'hFE, 8'hCA},
                exp_word: 32'hCAFE_F00D, exp_ferr: 0};
    vecs[3] = '{n_pre: 2, bad: 1'b1, bad_byte: 8'h5A, tx: '{8'h00, 8'hFF, 8'h80, 8'h01},
                exp_word: 32'h0180_FF00, exp_ferr: 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    idle(4);

    // Table vectors, consumer always ready
    set_ready(1'b1);
    foreach (vecs[v]) begin
      got_q.delete();
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      for (int i = 0; i < int'(vecs[v].n_pre); i++) send_byte(8'h99, 1'b1);
      if (vecs[v].bad) send_byte(vecs[v].bad_byte, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(vecs[v].tx[i], 1'b1);
      idle(4);
      check($sformatf("vec%0d_nwords", v), 32'(got_q.size()), 32'd1);
      check($sformatf("vec%0d_word", v), first_word(), vecs[v].exp_word);
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - o0), 32'd0);
    end

    // Overflow: buffer held full, second word dropped
    set_ready(1'b0);
    got_q.delete();
    o0 = ovr_cnt;
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h04, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(4);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_rdata", rdata, 32'hDEAD_BEEF);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_nwords", 32'(got_q.size()), 32'd0);
    set_ready(1'b1);
    check("ovr_valid_before_edge", 32'(valid), 32'd1);
    @(negedge clk);
    check("ovr_valid_fall", 32'(valid), 32'd0);
    check("ovr_drained", first_word(), 32'hDEAD_BEEF);

    // Short low glitch on an idle line
    got_q.delete();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("glitch_nwords", 32'(got_q.size()), 32'd0);
    send_byte(8'h21, 1'b1); send_byte(8'h43, 1'b1); send_byte(8'h65, 1'b1);
    send_byte(8'h87, 1'b1);
    idle(4);
    check("glitch_word", first_word(), 32'h8765_4321);

    // Reset mid-frame with a word pending
    set_ready(1'b0);
    send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(4);
    check("prerst_valid", 32'(valid), 32'd1);
    send_byte(8'h5C, 1'b1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_ferr", 32'(ferr), 32'd0);
    check("midrst_ovr", 32'(ovr), 32'd0);
    idle(2 * Cpb);
    set_ready(1'b1);
    got_q.delete();
    send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'hFE, 1'b1);
    send_byte(8'hCA, 1'b1);
    idle(4);
    check("postrst_nwords", 32'(got_q.size()), 32'd1);
    check("postrst_word", first_word(), 32'hCAFE_F00D);

    // Consume on exactly the cycle the next word completes
    set_ready(1'b0);
    got_q.delete();
    o0 = ovr_cnt;
    send_byte(8'hDD, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle(4);
    check("same_pending", 32'(valid), 32'd1);
    send_byte(8'h88, 1'b1); send_byte(8'h77, 1'b1); send_byte(8'h66, 1'b1);
    fork
      begin
        repeat (DoneEdge - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join_none
    send_byte(8'h55, 1'b1);
    idle(2);
    check("same_valid", 32'(valid), 32'd1);
    check("same_rdata", rdata, 32'h5566_7788);
    check("same_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("same_first", first_word(), 32'hAABB_CCDD);
    set_ready(1'b1);
    idle(2);
    check("same_nwords", 32'(got_q.size()), 32'd2);
    check("same_second", (got_q.size() > 1) ? got_q[1] : 32'hxxxx_xxxx, 32'h5566_7788);
    check("same_drained", 32'(valid), 32'd0);

    // Random frames against a byte-queue model
    got_q.delete();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    exp_ferr = 0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0]  b;
      logic        ok;
      logic [31:0] w;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_byte(b, ok);
      if (ok) begin
        pend.push_back(b);
        if (pend.size() == 4) begin
          w = 0;
          for (int i = 0; i < 4; i++) w = w + (32'(pend[i]) << (8 * i));
          exp_q.push_back(w);
          pend.delete();
        end
      end else begin
        pend.delete();
        exp_ferr++;
      end
      if ($urandom_range(0, 2) == 0) idle(Cpb * $urandom_range(1, 3));
    end
    idle(4);
    check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
    check("rand_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("rand_nwords", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      check($sformatf("rand_word%0d", i),
            (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Receive-side counterpart of the core's UART transmitter: deserialises 8N1 UART frames from the `rxd` pin, assembles four consecutive bytes into one 32-bit word, and presents it to the decode stage over a valid/ready handshake on the `uart_recv_*` path. It sits in `top` beside `uart_tx`, and its word interface feeds `decode`'s `uart_recv_data`, `uart_recv_valid` and `uart_recv_ready` ports.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Must be ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rdata`  out  32  assembled word; stable while `valid`=1.
- `valid`  out  1  `rdata` holds an unconsumed word.
- `ready`  in  1  consumer accepts the word; transfer happens when `valid && ready` at a rising edge.
- `ferr`  out  1  one-cycle pulse when a stop bit samples low.
- `ovr`  out  1  one-cycle pulse when a completed word is dropped because the buffer is full.

## Operation
- `rxd` passes through a 2-FF synchroniser, giving `rxs`. The synchroniser resets to 1.
- State machine: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: on `rxs`=0, go to `START` and load the bit counter with `CLK_PER_BIT/2 - 1`.
  - `START`: when the counter reaches 0, sample `rxs`. If it is 1 (glitch), return to `IDLE`. If it is 0, go to `DATA`, set the counter to `CLK_PER_BIT-1`, and set the bit index to 0.
  - `DATA`: at each counter expiry, sample `rxs` into `shift[bit_idx]` (LSB first) and reload the counter. After bit 7, go to `STOP`.
  - `STOP`: at counter expiry, sample `rxs`.
    - If 1: the byte is good. Write it into word byte lane `byte_cnt` (lane 0 = bits [7:0], little-endian). Then `byte_cnt` increments modulo 4. Return to `IDLE`.
    - If 0: pulse `ferr`, discard the byte, clear `byte_cnt` to 0 (resynchronise word alignment), and return to `IDLE`. While in `IDLE`, a new start is detected only after `rxs` has been seen high at least once (no re-triggering on a held-low line).
- Word completion happens on a good stop with `byte_cnt`=3.
  - If the output buffer is empty, or is being consumed this same cycle (`valid && ready`): load `rdata` from the assembled word and set `valid`=1.
  - Otherwise: pulse `ovr`, drop the new word, and leave `rdata` and `valid` unchanged.
- Handshake: once `valid` rises, it stays 1 and `rdata` stays constant until a cycle with `ready`=1. `valid` clears on the following edge unless a word completes in that same cycle; in that case `valid` stays 1 and `rdata` takes the new word.
- `ready` while `valid`=0 has no effect.
- Counter width is `$clog2(CLK_PER_BIT)`. No arithmetic beyond decrement/reload and a 3-bit bit index and 2-bit byte count.

## Timing
- Reset values: `rdata`=0, `valid`=0, `ferr`=0, `ovr`=0. State is `IDLE`, `byte_cnt`=0, synchroniser=1.
- Reset asserted mid-frame: on the next edge, abort the frame, discard partial bytes, and clear `valid` (any pending word is lost).
- Input latency: 2 cycles (synchroniser).
- Start bit is sampled at `CLK_PER_BIT/2` cycles after the falling edge seen at `rxs`. Data and stop bits are sampled at successive `CLK_PER_BIT` intervals (bit centres).
- `valid` rises on the edge immediately after the 4th byte's stop-bit sample (1 cycle after the sample). `ferr` and `ovr` pulse on that same edge.
- A receiver that goes `IDLE` after the stop-bit centre accepts back-to-back frames with no idle gap.
- Throughput: one word per 40 bit times. A consumer holding `ready`=1 never causes `ovr`.

## Test plan
- `CLK_PER_BIT`=16. Send bytes 0x78, 0x56, 0x34, 0x12 back-to-back with `ready`=1 → `valid` pulses once with `rdata`=0x12345678. `ferr`=0, `ovr`=0.
- `ready`=0. Send 8 bytes forming 0xDEADBEEF then 0x01020304 → `rdata` stays 0xDEADBEEF and `valid` stays 1. `ovr` pulses once at the end of the second word. Raising `ready` afterwards → `valid` falls next cycle.
- Send 0xAA with the stop bit driven 0, then 0x11, 0x22, 0x33, 0x44 → `ferr` pulses once, then `rdata`=0x44332211 (word alignment restarted after the error).
- Drive a 5-cycle low glitch on an idle `rxd` → no state change beyond `START`→`IDLE`. `valid`, `ferr` and `ovr` stay 0. A following valid 4-byte word is received correctly.
- Assert `rst` during the DATA bits of byte 2 of a word → all outputs 0 next cycle. A subsequent clean 4-byte word 0xCAFEF00D is received intact.
- Hold `valid`=1 and assert `ready` on exactly the cycle the next word completes → `valid` remains 1, `rdata` updates to the new word, and there is no `ovr` pulse.
